// File: rtl/xml_stream_scanner.sv
// xml_stream_scanner: byte-serial XML tokenizer with depth/sibling tracking and valid/ready pipeline.
// Optional XML_QUOTED_VALUE_EN: double-quoted attribute values may contain ' ', '/' and '>'.
module xml_stream_scanner #(
  parameter int MAX_DEPTH = 8,
  parameter int DEPTH_W   = 4,
  parameter int COUNT_W   = 8
) (
  input  logic                             CLOCK,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [7:0]                       in_data,
  input  logic                             in_newmsg,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [7:0]                       out_data,
  output logic                             out_newmsg,
  output logic                             is_data,
  output logic                             is_tag,
  output logic                             is_name,
  output logic                             is_key,
  output logic                             is_value,
  output logic                             is_comment,
  output logic [DEPTH_W-1:0]               depth,
  output logic                             depth_push,
  output logic                             depth_pop,
  output logic [(MAX_DEPTH+1)*COUNT_W-1:0] pos_flat,
  output logic                             err_overflow,
  output logic                             err_underflow
);
  localparam logic [3:0] S_DATA = 4'd0, S_LT = 4'd1, S_NAME = 4'd2, S_CNAME = 4'd3,
                         S_ATTR = 4'd4, S_KEY = 4'd5, S_VAL = 4'd6, S_SLASH = 4'd7,
                         S_BANG = 4'd8, S_BDASH = 4'd9, S_COMMENT = 4'd10, S_DECL = 4'd11;
`ifdef XML_QUOTED_VALUE_EN
  localparam logic [3:0] S_VALQ = 4'd12;
`endif
  localparam logic [DEPTH_W-1:0] DMAX = DEPTH_W'(MAX_DEPTH);
  logic [3:0] state, s, ns;
  logic [7:0] p1, p2, q1, q2;
  logic [DEPTH_W-1:0] d0, d_n;
  logic [COUNT_W-1:0] pos [0:MAX_DEPTH];
  logic [COUNT_W-1:0] pos_n [0:MAX_DEPTH];
  logic ovf_n, unf_n, acc, gt, sp, sl;
  logic f_tag, f_name, f_key, f_val, f_com, ev_open, ev_close, ev_self;
  assign in_ready = !out_valid || out_ready;
  assign acc = in_valid && in_ready;
  assign gt = in_data == ">";
  assign sp = in_data == " ";
  assign sl = in_data == "/";
  genvar k;
  generate
    for (k = 0; k <= MAX_DEPTH; k++) begin : g_pos
      assign pos_flat[k*COUNT_W +: COUNT_W] = pos[k];
    end
  endgenerate
  // A new message restarts from a clean context before this byte is classified.
  always_comb begin
    s = in_newmsg ? S_DATA : state;
    q1 = in_newmsg ? 8'h00 : p1;
    q2 = in_newmsg ? 8'h00 : p2;
    ns = s;
    f_tag = 1'b1;
    f_name = 1'b0;
    f_key = 1'b0;
    f_val = 1'b0;
    f_com = 1'b0;
    ev_open = 1'b0;
    ev_close = 1'b0;
    ev_self = 1'b0;
    case (s)
      S_DATA: begin
        f_tag = in_data == "<";
        ns = f_tag ? S_LT : S_DATA;
      end
      S_LT:
        if (sl) ns = S_CNAME;
        else if (in_data == "!") ns = S_BANG;
        else if (in_data == "?") ns = S_DECL;
        else if (gt) begin ev_open = 1'b1; ns = S_DATA; end
        else begin ns = S_NAME; f_name = !sp; end
      S_NAME, S_CNAME:
        if (sp) ns = S_ATTR;
        else if (gt) begin ns = S_DATA; ev_open = s == S_NAME; ev_close = s == S_CNAME; end
        else if (sl) ns = s == S_NAME ? S_SLASH : s;
        else f_name = 1'b1;
      S_ATTR:
        if (gt) begin ev_open = 1'b1; ns = S_DATA; end
        else if (sl) ns = S_SLASH;
        else if (!sp) begin ns = S_KEY; f_key = 1'b1; end
      S_KEY:
        if (in_data == "=") ns = S_VAL;
        else if (gt) begin ev_open = 1'b1; ns = S_DATA; end
        else if (sp) ns = S_ATTR;
        else if (sl) ns = S_SLASH;
        else f_key = 1'b1;
      S_VAL:
        if (gt) begin ev_open = 1'b1; ns = S_DATA; end
        else if (sp) ns = S_ATTR;
        else if (sl) ns = S_SLASH;
        else begin
          f_val = 1'b1;
`ifdef XML_QUOTED_VALUE_EN
          if (in_data == "\"" && q1 == "=") ns = S_VALQ;
`endif
        end
`ifdef XML_QUOTED_VALUE_EN
      S_VALQ: begin
        f_val = 1'b1;
        if (in_data == "\"") ns = S_VAL;
      end
`endif
      S_SLASH: if (gt) begin ev_self = 1'b1; ns = S_DATA; end
      S_BANG: ns = gt ? S_DATA : in_data == "-" ? S_BDASH : S_DECL;
      S_BDASH:
        if (in_data == "-") begin ns = S_COMMENT; f_tag = 1'b0; f_com = 1'b1; end
        else ns = gt ? S_DATA : S_DECL;
      S_COMMENT: begin
        f_tag = 1'b0;
        f_com = 1'b1;
        if (gt && q1 == "-" && q2 == "-") ns = S_DATA;
      end
      S_DECL: if (gt) ns = S_DATA;
      default: ns = S_DATA;
    endcase
  end
  always_comb begin
    d0 = in_newmsg ? '0 : depth;
    d_n = d0;
    ovf_n = !in_newmsg && err_overflow;
    unf_n = !in_newmsg && err_underflow;
    for (int i = 0; i <= MAX_DEPTH; i++) pos_n[i] = in_newmsg ? '0 : pos[i];
    if (ev_open) begin
      if (d0 == DMAX) ovf_n = 1'b1;
      else d_n = d0 + 1'b1;
    end
    if (ev_close) begin
      if (d0 == '0) unf_n = 1'b1;
      else begin
        d_n = d0 - 1'b1;
        pos_n[d0 - 1'b1] = pos_n[d0 - 1'b1] + 1'b1;
        pos_n[d0] = '0;
      end
    end
    if (ev_self) begin
      pos_n[d0] = pos_n[d0] + 1'b1;
      if (d0 < DMAX) pos_n[d0 + 1'b1] = '0;
    end
  end
  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state <= S_DATA;
      p1 <= '0;
      p2 <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_newmsg <= 1'b0;
      {is_data, is_tag, is_name, is_key, is_value, is_comment} <= '0;
      depth <= '0;
      depth_push <= 1'b0;
      depth_pop <= 1'b0;
      pos <= '{default: '0};
      err_overflow <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (acc || out_ready) out_valid <= acc;
      if (acc) begin
        state <= ns;
        p1 <= in_data;
        p2 <= q1;
        out_data <= in_data;
        out_newmsg <= in_newmsg;
        is_data <= !f_tag && !f_com;
        is_tag <= f_tag;
        is_name <= f_name;
        is_key <= f_key;
        is_value <= f_val;
        is_comment <= f_com;
        depth <= d_n;
        depth_push <= ev_open && d0 != DMAX;
        depth_pop <= ev_close && d0 != '0;
        pos <= pos_n;
        err_overflow <= ovf_n;
        err_underflow <= unf_n;
      end
    end
  end
endmodule
